alu_secuencial: RTL

- Execution unit directly downstream of the ALU control decoder; consumes its 4-bit operation code and 3-bit branch code.
- Logic, arithmetic and compare ops complete in one cycle.
- Shifts run iteratively, one bit per cycle, behind a start/busy/done handshake.
- The core stalls on ocupado_o.
- Also resolves the branch-taken decision from the registered result.

---
 rtl/alu_secuencial.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/alu_secuencial.sv
// Sequential ALU: single-cycle logic/arith/compare ops, iterative 1-bit/cycle shifts, branch resolution.
// Optional build macro ALU_BARREL_SHIFT_EN replaces the iterative shifter with a combinational barrel shifter.
module alu_secuencial #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             inicio_i,
   input  logic [3:0]       aluoperacion_i,
   input  logic [2:0]       branch_ctrl_i,
   input  logic             es_branch_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] resultado_o,
   output logic             cero_o,
   output logic             salto_o,
   output logic             ocupado_o,
   output logic             listo_o,
   output logic             error_o
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SLTU = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;

   typedef enum logic [1:0] {INACTIVO, DESPLAZA, FIN} estado_t;

   estado_t          estado_reg;
   logic [3:0]       op_reg;
   logic [2:0]       br_reg;
   logic             esb_reg;
   logic [SHW-1:0]   cnt_reg;
   logic [WIDTH-1:0] work_reg;
   logic [WIDTH-1:0] resultado_reg;
   logic             cero_reg, salto_reg, ocupado_reg, listo_reg, error_reg;

   function automatic logic es_desp(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   function automatic logic es_legal(input logic [3:0] op);
      return (op <= OP_SLTU) || es_desp(op);
   endfunction

   function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] x);
      case (op)
         OP_SLL:  return {x[WIDTH-2:0], 1'b0};
         OP_SRL:  return {1'b0, x[WIDTH-1:1]};
         default: return {x[WIDTH-1], x[WIDTH-1:1]};
      endcase
   endfunction

   // Branch decision is taken from the value about to be registered, so it lands with listo_o.
   function automatic logic salto_calc(input logic esb, input logic [2:0] br,
                                       input logic [WIDTH-1:0] res, input logic ilegal);
      logic z;
      z = (res == '0);
      if (!esb || ilegal) return 1'b0;
      case (br)
         3'b000:          return z;
         3'b001:          return !z;
         3'b100, 3'b110:  return res[0];
         3'b101, 3'b111:  return !res[0];
         default:         return 1'b0;
      endcase
   endfunction

   logic [SHW-1:0]   amt;
   logic [WIDTH-1:0] res_inmediato;
   logic [WIDTH-1:0] res_desp;
   logic [WIDTH-1:0] fin_res;
   logic             fin_ilegal, fin_salto;

   assign amt      = b_i[SHW-1:0];
   assign res_desp = shift1(op_reg, work_reg);

   always_comb begin
      res_inmediato = '0;
      case (aluoperacion_i)
         OP_AND:  res_inmediato = a_i & b_i;
         OP_OR:   res_inmediato = a_i | b_i;
         OP_ADD:  res_inmediato = a_i + b_i;
         OP_SUB:  res_inmediato = a_i - b_i;
         OP_XOR:  res_inmediato = a_i ^ b_i;
         OP_SLT:  res_inmediato = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         OP_SLTU: res_inmediato = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
`ifdef ALU_BARREL_SHIFT_EN
         OP_SLL:  res_inmediato = a_i << amt;
         OP_SRL:  res_inmediato = a_i >> amt;
         OP_SRA:  res_inmediato = WIDTH'($signed(a_i) >>> amt);
`else
         // Only the amount-0 case reaches FIN directly; longer shifts go through DESPLAZA.
         OP_SLL, OP_SRL, OP_SRA: res_inmediato = a_i;
`endif
         default: res_inmediato = '0;
      endcase
   end

   always_comb begin
      if (estado_reg == DESPLAZA) begin
         fin_res    = res_desp;
         fin_ilegal = 1'b0;
         fin_salto  = salto_calc(esb_reg, br_reg, res_desp, 1'b0);
      end else begin
         fin_res    = res_inmediato;
         fin_ilegal = !es_legal(aluoperacion_i);
         fin_salto  = salto_calc(es_branch_i, branch_ctrl_i, res_inmediato, !es_legal(aluoperacion_i));
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         estado_reg    <= INACTIVO;
         op_reg        <= '0;
         br_reg        <= '0;
         esb_reg       <= 1'b0;
         cnt_reg       <= '0;
         work_reg      <= '0;
         resultado_reg <= '0;
         cero_reg      <= 1'b1;
         salto_reg     <= 1'b0;
         ocupado_reg   <= 1'b0;
         listo_reg     <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         listo_reg <= 1'b0;
         error_reg <= 1'b0;
         case (estado_reg)
            INACTIVO: begin
               if (inicio_i) begin
                  op_reg  <= aluoperacion_i;
                  br_reg  <= branch_ctrl_i;
                  esb_reg <= es_branch_i;
`ifndef ALU_BARREL_SHIFT_EN
                  if (es_desp(aluoperacion_i) && (amt != '0)) begin
                     estado_reg  <= DESPLAZA;
                     cnt_reg     <= amt;
                     work_reg    <= a_i;
                     ocupado_reg <= 1'b1;
                  end else
`endif
                  begin
                     estado_reg    <= FIN;
                     resultado_reg <= fin_res;
                     cero_reg      <= (fin_res == '0);
                     salto_reg     <= fin_salto;
                     error_reg     <= fin_ilegal;
                     listo_reg     <= 1'b1;
                  end
               end
            end
            DESPLAZA: begin
               work_reg <= res_desp;
               cnt_reg  <= cnt_reg - 1'b1;
               if (cnt_reg == SHW'(1)) begin
                  estado_reg    <= FIN;
                  ocupado_reg   <= 1'b0;
                  resultado_reg <= fin_res;
                  cero_reg      <= (fin_res == '0);
                  salto_reg     <= fin_salto;
                  error_reg     <= fin_ilegal;
                  listo_reg     <= 1'b1;
               end
            end
            default: estado_reg <= INACTIVO;
         endcase
      end
   end

   assign resultado_o = resultado_reg;
   assign cero_o      = cero_reg;
   assign salto_o     = salto_reg;
   assign ocupado_o   = ocupado_reg;
   assign listo_o     = listo_reg;
   assign error_o     = error_reg;

endmodule
